// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter
// Purpose  : Shares one single-ported synchronous memory between the I-fetch
//            and load/store ports. D has priority, and a starvation counter
//            guarantees that I makes forward progress.
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ren,
    input  logic [AW-1:0] i_raddr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_ren,
    input  logic          d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic [AW-1:0] m_addr,
    output logic          m_ren,
    output logic          m_wen,
    output logic [31:0]   m_wdata,
    output logic [3:0]    m_wstrb,
    input  logic [31:0]   m_rdata
);

    localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_resp_i;
    logic               r_resp_d;
    logic [31:0]        r_i_hold;
    logic [31:0]        r_d_hold;

    logic               w_d_req;
    logic               w_i_force;
    logic               w_i_take;
    logic               w_d_take;

    assign w_d_req   = d_ren | d_wen;
    assign w_i_force = (r_starve_cnt == c_STARVE_MAX) & i_ren;

    assign i_gnt = w_i_force | (~w_d_req & i_ren);
    assign d_gnt = ~w_i_force & w_d_req;

    always_comb begin
        m_addr  = '0;
        m_ren   = 1'b0;
        m_wen   = 1'b0;
        m_wdata = '0;
        m_wstrb = '0;
        if (i_gnt) begin
            m_addr = i_raddr;
            m_ren  = 1'b1;
        end else if (d_gnt) begin
            // A simultaneous read+write request is treated as a pure write.
            m_addr  = d_addr;
            m_wen   = d_wen;
            m_ren   = d_ren & ~d_wen;
            m_wdata = d_wdata;
            m_wstrb = d_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_resp_i     <= 1'b0;
            r_resp_d     <= 1'b0;
            r_i_hold     <= '0;
            r_d_hold     <= '0;
        end else begin
            if (i_ren & ~i_gnt) begin
                if (r_starve_cnt != c_STARVE_MAX)
                    r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end else begin
                r_starve_cnt <= '0;
            end
            r_resp_i <= i_gnt;
            r_resp_d <= d_gnt & m_ren;
            if (r_resp_i)
                r_i_hold <= m_rdata;
            if (r_resp_d)
                r_d_hold <= m_rdata;
        end
    end

    // Responses still in flight when reset is applied are dropped, not shown.
    assign w_i_take = r_resp_i & ~rst;
    assign w_d_take = r_resp_d & ~rst;

    assign i_rvalid = w_i_take;
    assign d_rvalid = w_d_take;
    assign i_rdata  = w_i_take ? m_rdata : r_i_hold;
    assign d_rdata  = w_d_take ? m_rdata : r_d_hold;

endmodule
`default_nettype wire
